// File: rtl/sccb_pkg.sv
// sccb_pkg: shared SCCB states, device IDs and frame constants.
package sccb_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_START1, S_ID_W, S_SUB, S_STOP1, S_GAP,
        S_START2, S_ID_R, S_RD, S_NA, S_STOP2, S_DONE
    } state_t;

    localparam logic [7:0] SCCB_WR_ID = 8'h42;
    localparam logic [7:0] SCCB_RD_ID = 8'h43;
    localparam int TICKS_PER_BIT = 4;
    localparam int FRAME_BITS = 41;

    // Number of bit-times spent in each bus phase.
    function automatic logic [3:0] phase_bits(input state_t s);
        return (s == S_ID_W || s == S_SUB || s == S_ID_R) ? 4'd9 : s == S_RD ? 4'd8 : 4'd1;
    endfunction
endpackage

// File: rtl/sccb_tick_gen.sv
// sccb_tick_gen: quarter-bit tick divider with 2-bit phase (q0..q3); holds cleared while disabled.
module sccb_tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       tick,
    output logic [1:0] phase
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] cnt;

    assign tick = en && cnt == CW'(CLK_DIV - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            phase <= '0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= '0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/sccb_reader.sv
// sccb_reader: SCCB register read (sub-address write cycle, then 1-byte read cycle).
// Optional ACK checking with early abort is enabled by SCCB_READER_ACK_CHECK_EN.
module sccb_reader
    import sccb_pkg::*;
#(
    parameter int         CLK_DIV = 50,
    parameter logic [7:0] DEV_ID  = SCCB_WR_ID
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  reg_addr,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        ack_err,
    output logic        scl,
    inout  wire         sda,
    output logic [31:0] debug_out
);
    state_t      state, state_n;
    logic [3:0]  bit_cnt;
    logic [7:0]  reg_addr_q, rx, tx_byte;
    logic [1:0]  phase;
    logic        tick, bit_end, last_bit, is_start, is_stop, is_tx, is_rx, sda_low;
    logic        nack_now, keep_rd;

    assign busy = state != S_IDLE;

    sccb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .tick (tick),
        .phase(phase)
    );

    assign bit_end  = tick && phase == 2'd3;
    assign last_bit = bit_cnt == phase_bits(state) - 4'd1;
    assign is_start = state == S_START1 || state == S_START2;
    assign is_stop  = state == S_STOP1 || state == S_STOP2;
    assign is_tx    = state == S_ID_W || state == S_SUB || state == S_ID_R;
    assign is_rx    = state == S_RD || state == S_NA;
    assign tx_byte  = state == S_ID_W ? DEV_ID : state == S_SUB ? reg_addr_q : DEV_ID | 8'h01;

    // SDA only ever changes at q0 except inside START/STOP, where it moves with SCL high.
    assign scl     = is_start ? phase != 2'd3 : (is_stop || is_tx || is_rx) ? phase[1] : 1'b1;
    assign sda_low = is_start ? phase[1] : is_stop ? phase != 2'd3 :
                     is_tx && !bit_cnt[3] && !tx_byte[~bit_cnt[2:0]];
    assign sda     = sda_low ? 1'b0 : 1'bz;

    assign debug_out = {4'd0, state, 4'd0, bit_cnt, reg_addr_q, rd_data};

`ifdef SCCB_READER_ACK_CHECK_EN
    logic nack;
    assign nack_now = bit_end && is_tx && bit_cnt == 4'd8 && sda;
    assign keep_rd  = nack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nack    <= 1'b0;
            ack_err <= 1'b0;
        end else if (state == S_IDLE) begin
            nack <= 1'b0;
        end else if (nack_now) begin
            nack <= 1'b1;
        end else if (state == S_DONE) begin
            ack_err <= nack;
        end
    end
`else
    assign nack_now = 1'b0;
    assign keep_rd  = 1'b0;
    assign ack_err  = 1'b0;
`endif

    always_comb begin
        state_n = state;
        if (state == S_IDLE)
            state_n = start && !done ? S_START1 : S_IDLE;
        else if (state == S_DONE)
            state_n = S_IDLE;
        else if (bit_end)
            state_n = nack_now ? S_STOP2 : last_bit ? state_t'(state + 4'd1) : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            reg_addr_q <= '0;
            rx         <= '0;
            rd_data    <= '0;
            done       <= 1'b0;
        end else begin
            state   <= state_n;
            done    <= state == S_DONE;
            bit_cnt <= state_n != state ? 4'd0 : bit_end ? bit_cnt + 4'd1 : bit_cnt;
            if (state == S_IDLE && state_n == S_START1)
                reg_addr_q <= reg_addr;
            if (bit_end && state == S_RD)
                rx <= {rx[6:0], sda};
            if (state == S_DONE && !keep_rd)
                rd_data <= rx;
        end
    end
endmodule

// File: tb/tb_sccb_reader.sv
// tb_sccb_reader: randomized scoreboard bench with a bus-level SCCB slave and a frame-level reference model.
module tb_sccb_reader;
    localparam int D = 4;
    localparam int FULL_TICKS = (1 + 9 + 9 + 1 + 1 + 1 + 9 + 8 + 1 + 1) * 4;
    localparam int NACK_TICKS = (1 + 9 + 1) * 4;

    logic        clk = 0, rst = 0, start = 0;
    logic [7:0]  reg_addr = 0;
    logic        busy, done, ack_err, scl;
    logic [7:0]  rd_data;
    logic [31:0] debug_out;
    wire         sda;
    logic        s_drv = 0;

    pullup (sda);
    assign sda = s_drv ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    sccb_reader #(.CLK_DIV(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .reg_addr (reg_addr),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .ack_err  (ack_err),
        .scl      (scl),
        .sda      (sda),
        .debug_out(debug_out)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: register file answering reads of the last written sub-address.
    logic [7:0] mem [256];
    logic [7:0] byte_q [$];
    logic [7:0] sh = 0, sub = 0, rdat = 0;
    logic       pscl = 1, psda = 1;
    bit         rmode = 0, nack_en = 0;
    int         sbit = 0, sbyte = 0, n_starts = 0, n_stops = 0;

    always @(negedge clk) begin
        if (!rst) begin
            s_drv = 0; sbit = 0; sbyte = 0; rmode = 0;
        end else if (scl && pscl && psda && !sda) begin
            n_starts++; sbit = 0; sbyte = 0; rmode = 0; s_drv = 0;
        end else if (scl && pscl && !psda && sda) begin
            n_stops++; s_drv = 0;
        end else if (scl && !pscl) begin
            if (!(rmode && sbyte == 1)) sh = {sh[6:0], sda};
            sbit++;
        end else if (!scl && pscl) begin
            if (sbit == 8) begin
                if (rmode && sbyte == 1) s_drv = 0;
                else begin
                    byte_q.push_back(sh);
                    if (sbyte == 0) rmode = sh[0];
                    if (sbyte == 1 && !rmode) sub = sh;
                    s_drv = !(nack_en && sbyte == 0 && !sh[0]);
                end
            end else if (sbit == 9) begin
                sbit = 0; sbyte++; s_drv = 0;
                if (rmode && sbyte == 1) begin rdat = mem[sub]; s_drv = !rdat[7]; end
            end else if (rmode && sbyte == 1 && sbit < 8) begin
                s_drv = !rdat[7 - sbit];
            end
        end
        pscl = scl; psda = sda;
    end

    typedef struct {
        logic [7:0] rd;
        logic       err;
        logic [7:0] addr;
        int lat, nst, nb, acc, sb, pb, bb;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] model_rd = 0;
    int         errs = 0, checks = 0, ndone = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input bit nk);
        exp_t e;
        bit early = 0;
`ifdef SCCB_READER_ACK_CHECK_EN
        early = nk;
`endif
        e.addr = a; e.acc = cyc + 1; e.sb = n_starts; e.pb = n_stops; e.bb = byte_q.size();
        if (early) begin
            e.rd = model_rd; e.err = 1; e.lat = NACK_TICKS * D + 1; e.nst = 1; e.nb = 1;
        end else begin
            e.rd = mem[a]; e.err = 0; e.lat = FULL_TICKS * D + 1; e.nst = 2; e.nb = 3;
        end
        model_rd = e.rd;
        exp_q.push_back(e);
    endtask

    task automatic check_done();
        exp_t e;
        int nb;
        if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(exp_q.size()), 1);
        end else begin
            e = exp_q.pop_front();
            nb = byte_q.size() - e.bb;
            chk("rd_data", 32'(rd_data), 32'(e.rd));
            chk("ack_err", 32'(ack_err), 32'(e.err));
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("busy_at_done", 32'(busy), 0);
            chk("starts", 32'(n_starts - e.sb), 32'(e.nst));
            chk("stops", 32'(n_stops - e.pb), 32'(e.nst));
            chk("byte_count", 32'(nb), 32'(e.nb));
            for (int i = 0; i < e.nb && i < nb; i++)
                chk("bus_byte", 32'(byte_q[e.bb + i]), i == 0 ? 32'h42 : i == 1 ? 32'(e.addr) : 32'h43);
        end
        ndone++;
    endtask

    task automatic wait_done(input int n0);
        for (int i = 0; i < 200 * 4 * D && ndone == n0; i++) @(negedge clk);
        chk("done_seen", 32'(ndone - n0), 1);
    endtask

    task automatic do_txn(input logic [7:0] a, input bit nk, input int pulses);
        int n0;
        for (int i = 0; i < 50 && (busy || done); i++) @(negedge clk);
        nack_en = nk; reg_addr = a; start = 1;
        push_exp(a, nk);
        n0 = ndone;
        @(negedge clk);
        start = 0; reg_addr = 8'($urandom);
        for (int p = 0; p < pulses; p++) begin
            repeat ($urandom_range(5, 100)) @(negedge clk);
            start = 1;
            @(negedge clk);
            start = 0;
        end
        wait_done(n0);
        repeat (8) @(negedge clk);
        chk("idle_after", 32'(busy), 0);
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h0A] = 8'h76;
        mem[8'h0B] = 8'h73;
        fork
            forever begin
                @(negedge clk);
                if (done) check_done();
            end
        join_none

        start = 1; reg_addr = 8'h0A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_scl", 32'(scl), 1);
            chk("rst_sda", 32'(sda), 1);
            chk("rst_busy", 32'(busy), 0);
        end
        chk("rst_rd_data", 32'(rd_data), 0);
        rst = 1;
        push_exp(8'h0A, 0);
        n0 = ndone;
        @(negedge clk);
        start = 0;
        chk("accept_busy", 32'(busy), 1);
        wait_done(n0);

        do_txn(8'h0B, 0, 3);
        do_txn(8'h0A, 1, 0);
        for (int t = 0; t < 6; t++)
            do_txn(8'($urandom_range(0, 255)), 0, $urandom_range(0, 2));

        nack_en = 0; reg_addr = 8'h0A; start = 1;
        push_exp(8'h0A, 0);
        @(negedge clk);
        start = 0;
        repeat ((31 + 4) * 4 * D + 2 * D) @(negedge clk);
        rst = 0;
        exp_q.delete();
        model_rd = 0;
        #1;
        chk("mid_rst_scl", 32'(scl), 1);
        chk("mid_rst_sda", 32'(sda), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_rd_data", 32'(rd_data), 0);
        chk("mid_rst_ack_err", 32'(ack_err), 0);
        repeat (3) @(negedge clk);
        rst = 1;
        do_txn(8'h0A, 0, 1);

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
